// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller of an async FIFO, entirely in the r_clk domain.
// It compares the binary read pointer with the synchronised write pointer and
// issues reads to a RAM with 1-cycle registered read latency. Words are presented
// on a valid/ready stream through a 2-entry first-word-fall-through prefetch buffer.
// Optional feature macro: RD_LEVEL_EN adds the rd_level occupancy output.
//
// Stream handshake: a word transfers on every r_clk edge where dout_valid and
// dout_ready are both high. While dout_valid is high without dout_ready, dout_data
// and dout_valid hold. dout_valid only falls after a transfer or on reset.
module fifo_read_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              r_clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   w_ptrsync,
    output logic [ADDR_W:0]   r_ptr,
    output logic              empty,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef RD_LEVEL_EN
    output logic [ADDR_W+1:0] rd_level,
`endif
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready
);

    // Prefetch buffer: entry 0 is always the head presented on the stream.
    logic [DATA_W-1:0] buf0_q, buf1_q;
    logic [DATA_W-1:0] buf0_n, buf1_n;
    logic [1:0]        buf_cnt, cnt_n;
    // High in the cycle the RAM is returning the word requested one cycle earlier.
    logic              inflight;
    logic              pop;
    logic              fetch;
    logic [2:0]        occ;

    assign empty      = (r_ptr == w_ptrsync);
    assign mem_raddr  = r_ptr[ADDR_W-1:0];
    assign mem_ren    = fetch;
    assign dout_valid = (buf_cnt != 2'd0);
    assign dout_data  = buf0_q;

`ifdef RD_LEVEL_EN
    // Words still owed to the consumer: unread in RAM, buffered, and in flight.
    assign rd_level = {1'b0, (w_ptrsync - r_ptr)}
                    + {{ADDR_W{1'b0}}, buf_cnt}
                    + {{(ADDR_W+1){1'b0}}, inflight};
`endif

    // Fetch decision: read only while the RAM has data and the buffer has room
    // for the returning word, counting the word leaving in this same cycle.
    always_comb begin
        pop   = dout_valid & dout_ready;
        occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        fetch = !rst && !empty && (occ < 3'd2);
    end

    // Buffer next state: pop shifts the head out, then a returning word lands at the tail.
    always_comb begin
        buf0_n = buf0_q;
        buf1_n = buf1_q;
        cnt_n  = buf_cnt;
        if (pop) begin
            buf0_n = buf1_q;
            cnt_n  = buf_cnt - 2'd1;
        end
        if (inflight) begin
            if (cnt_n == 2'd0) begin
                buf0_n = mem_rdata;
            end else begin
                buf1_n = mem_rdata;
            end
            cnt_n = cnt_n + 2'd1;
        end
    end

    // State registers; reset drops any word still in flight from the RAM.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_ptr    <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf0_q   <= '0;
            buf1_q   <= '0;
        end else begin
            if (fetch) begin
                r_ptr <= r_ptr + {{ADDR_W{1'b0}}, 1'b1};
            end
            inflight <= fetch;
            buf_cnt  <= cnt_n;
            buf0_q   <= buf0_n;
            buf1_q   <= buf1_n;
        end
    end

endmodule
